// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the RV32I fetch front end.
// Word-indexed PCs throughout: byte address = pc * 4.
package rv32i_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // stale is the LSB so a generic FIFO can flag it in place
  typedef struct packed {
    logic [31:0] pc;
    logic        stale;
  } inflight_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count, flush, and an optional
// mark input that forces the LSB of every stored entry to 1.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 2,
  parameter bit MARK_EN = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_din,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic                   i_mark,
  output logic [DATA_W-1:0]      o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_count;
  logic [DEPTH-1:0]  r_mark;
  logic [DEPTH-1:0]  w_mark_nxt;
  logic              w_head_mark;

  // A freshly pushed entry is never marked, even if mark fires the same cycle
  always_comb begin
    w_mark_nxt = r_mark | {DEPTH{i_mark}};
    if (i_push) w_mark_nxt[r_wr_ptr] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_mark   <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_mark   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      r_mark  <= w_mark_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign w_head_mark = MARK_EN && r_mark[r_rd_ptr];
  assign o_head      = {r_mem[r_rd_ptr][DATA_W-1:1], r_mem[r_rd_ptr][0] | w_head_mark};
  assign o_count     = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues word-indexed requests to a synchronous
// instruction memory and presents buffered {valid, pc, instr} to IF/ID.
module if_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FB_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        EN_PC_O,
  output logic [31:0] PC_O,
  output logic [31:0] instr_O
);

  localparam int CW = $clog2(FB_DEPTH) + 1;

  logic [31:0]   r_pc;
  fetch_entry_t  r_last;
  logic [CW-1:0] w_if_cnt;
  logic [CW-1:0] w_fb_cnt;
  logic [CW:0]   w_load;
  inflight_t     w_if_head;
  inflight_t     w_if_din;
  fetch_entry_t  w_fb_head;
  fetch_entry_t  w_fb_din;
  logic          w_issue;
  logic          w_if_pop;
  logic          w_fb_push;
  logic          w_fb_pop;
  logic          w_en;

  assign w_en     = (w_fb_cnt != '0);
  assign w_fb_pop = w_en && !stall && !redirect;

  // A head leaving this cycle frees its credit immediately, which is what
  // lets a FB_DEPTH=2 buffer sustain one instruction per cycle.
  assign w_load   = {1'b0, w_if_cnt} + {1'b0, w_fb_cnt} - (CW+1)'(w_fb_pop);
  assign imem_req = rst_n && !redirect && (w_load < (CW+1)'(FB_DEPTH));
  assign w_issue  = imem_req && imem_gnt;
  assign imem_addr = r_pc;

  assign w_if_pop  = imem_rvalid && (w_if_cnt != '0);
  assign w_fb_push = w_if_pop && !w_if_head.stale && !redirect;
  assign w_if_din  = '{pc: r_pc, stale: 1'b0};
  assign w_fb_din  = '{pc: w_if_head.pc, instr: imem_rdata};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= redirect_pc;
    end else if (w_issue) begin
      r_pc <= pc_next(r_pc);
    end
  end

  // Remembers the last presented head so outputs hold while the buffer is empty
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_en) begin
      r_last <= w_fb_head;
    end
  end

  fetch_fifo #(
    .DATA_W  ($bits(inflight_t)),
    .DEPTH   (FB_DEPTH),
    .MARK_EN (1'b1)
  ) u_inflight_q (
    .i_clk   (CLK),
    .i_rst_n (rst_n),
    .i_push  (w_issue),
    .i_din   (w_if_din),
    .i_pop   (w_if_pop),
    .i_flush (1'b0),
    .i_mark  (redirect),
    .o_head  (w_if_head),
    .o_count (w_if_cnt)
  );

  fetch_fifo #(
    .DATA_W  ($bits(fetch_entry_t)),
    .DEPTH   (FB_DEPTH),
    .MARK_EN (1'b0)
  ) u_fetch_buf (
    .i_clk   (CLK),
    .i_rst_n (rst_n),
    .i_push  (w_fb_push),
    .i_din   (w_fb_din),
    .i_pop   (w_fb_pop),
    .i_flush (redirect),
    .i_mark  (1'b0),
    .o_head  (w_fb_head),
    .o_count (w_fb_cnt)
  );

  assign EN_PC_O = w_en;
  assign PC_O    = w_en ? w_fb_head.pc    : r_last.pc;
  assign instr_O = w_en ? w_fb_head.instr : r_last.instr;

  a_rvalid_has_req: assert property (@(posedge CLK) disable iff (!rst_n)
    imem_rvalid |-> (w_if_cnt != '0));

  a_credit_bound: assert property (@(posedge CLK) disable iff (!rst_n)
    ({1'b0, w_if_cnt} + {1'b0, w_fb_cnt}) <= (CW+1)'(FB_DEPTH));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model, consume monitor, and
// per-scenario tasks checked against a program-order PC model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        EN_PC_O;
  logic [31:0] PC_O;
  logic [31:0] instr_O;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FB_DEPTH(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .EN_PC_O(EN_PC_O), .PC_O(PC_O), .instr_O(instr_O)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // In-order memory: each handshake returns mem_word(addr) after lat cycles
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          k = 0;
  int          lat = 1;
  bit          rand_lat = 1'b0;
  logic        s_hs = 1'b0;
  logic [31:0] s_addr = '0;

  always @(negedge CLK) begin
    s_hs   = imem_req & imem_gnt;
    s_addr = imem_addr;
  end

  always begin : mem_model
    int l;
    @(posedge CLK); #1;
    k++;
    if (!rst_n) begin
      mq.delete();
      imem_rvalid = 1'b0;
    end else begin
      if (s_hs) begin
        l = rand_lat ? int'($urandom_range(3, 1)) : lat;
        mq.push_back('{s_addr, k + l - 1});
      end
      if (mq.size() > 0 && mq[0].due <= k) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Records every instruction IF/ID actually accepts
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];
  logic        m_c = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_in = '0;

  always @(negedge CLK) begin
    m_c  = EN_PC_O & !stall & !redirect & rst_n;
    m_pc = PC_O;
    m_in = instr_O;
  end

  always @(posedge CLK) begin
    if (m_c && rst_n) begin
      got_pc.push_back(m_pc);
      got_in.push_back(m_in);
    end
  end

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b1;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    got_pc.delete(); got_in.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_tests++; if (EN_PC_O !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", EN_PC_O); end
    n_tests++; if (PC_O !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", PC_O); end
    n_tests++; if (instr_O !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr_O); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_tests++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    lat = 1; rand_lat = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_tests++;
      if (imem_addr !== RESET_PC + 32'(i)) begin
        n_fail++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", i, imem_addr, RESET_PC + 32'(i));
      end
      n_tests++;
      if (EN_PC_O !== (i >= 2)) begin
        n_fail++; $display("FAIL stream_en cyc=%0d got=%b exp=%b", i, EN_PC_O, (i >= 2));
      end
      if (i >= 2) begin
        n_tests++;
        if (PC_O !== RESET_PC + 32'(i - 2) || instr_O !== mem_word(RESET_PC + 32'(i - 2))) begin
          n_fail++; $display("FAIL stream_head cyc=%0d got=%h/%h exp=%h/%h", i, PC_O, instr_O,
                             RESET_PC + 32'(i - 2), mem_word(RESET_PC + 32'(i - 2)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic [31:0] hpc, hin;
    int n0;
    hpc = '0; hin = '0;
    stall = 1'b1;
    n0 = got_pc.size();
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      if (j == 0) begin
        hpc = PC_O; hin = instr_O;
      end else begin
        n_tests++;
        if (PC_O !== hpc || instr_O !== hin || EN_PC_O !== 1'b1) begin
          n_fail++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%b exp=%h/%h/1", j, PC_O, instr_O, EN_PC_O, hpc, hin);
        end
      end
      if (j == 4) begin
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got=%b exp=0", imem_req); end
      end
      next_cycle();
    end
    stall = 1'b0;
    n_tests++;
    if (got_pc.size() !== n0) begin n_fail++; $display("FAIL stall_consumed got=%0d exp=%0d", got_pc.size(), n0); end
    repeat (6) next_cycle();
    n_tests++;
    if (got_pc.size() !== 14) begin n_fail++; $display("FAIL stall_count got=%0d exp=14", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_tests++;
      if (got_pc[i] !== RESET_PC + 32'(i) || got_in[i] !== mem_word(RESET_PC + 32'(i))) begin
        n_fail++; $display("FAIL stall_seq idx=%0d got=%h/%h exp=%h", i, got_pc[i], got_in[i], RESET_PC + 32'(i));
      end
    end
  endtask

  task automatic test_gnt_wait();
    logic [31:0] a;
    a = '0;
    imem_gnt = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      if (j == 0) a = imem_addr;
      else begin
        n_tests++;
        if (imem_addr !== a) begin n_fail++; $display("FAIL gnt_hold cyc=%0d got=%h exp=%h", j, imem_addr, a); end
      end
      next_cycle();
    end
    imem_gnt = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (imem_addr !== a || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL gnt_release got=%h/%b exp=%h/1", imem_addr, imem_req, a);
    end
    next_cycle();
    @(negedge CLK);
    n_tests++;
    if (imem_addr !== a + 32'd1) begin n_fail++; $display("FAIL gnt_advance got=%h exp=%h", imem_addr, a + 32'd1); end
    repeat (5) next_cycle();
    for (int i = 0; i < got_pc.size(); i++) begin
      n_tests++;
      if (got_pc[i] !== RESET_PC + 32'(i)) begin
        n_fail++; $display("FAIL gnt_seq idx=%0d got=%h exp=%h", i, got_pc[i], RESET_PC + 32'(i));
      end
    end
  endtask

  task automatic wait_first_head(input string nm, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLK);
      if (EN_PC_O === 1'b1) begin
        seen = 1'b1;
        n_tests++;
        if (PC_O !== exp_pc || instr_O !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL %s_head got=%h/%h exp=%h/%h", nm, PC_O, instr_O, exp_pc, mem_word(exp_pc));
        end
      end
      next_cycle();
    end
    if (!seen) begin
      n_tests++; n_fail++; $display("FAIL %s_timeout got=no_valid exp=valid", nm);
    end
  endtask

  task automatic test_redirect();
    lat = 2; rand_lat = 1'b0;
    do_reset();
    repeat (2) next_cycle();
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge CLK);
    n_tests++;
    if (imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL redir_cycle got=req%b/rv%b exp=req0/rv1", imem_req, imem_rvalid);
    end
    next_cycle();
    redirect = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || EN_PC_O !== 1'b0) begin
      n_fail++; $display("FAIL redir_resume got=req%b/%h/en%b exp=req1/00000040/en0", imem_req, imem_addr, EN_PC_O);
    end
    wait_first_head("redir", 32'h40);
  endtask

  task automatic test_redirect_stall();
    logic [31:0] rpc;
    lat = 1; rand_lat = 1'b0;
    do_reset();
    repeat (6) next_cycle();
    rpc = $urandom;
    stall = 1'b1; redirect = 1'b1; redirect_pc = rpc;
    @(negedge CLK);
    n_tests++;
    if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstall_cycle got=rv%b/req%b exp=rv1/req0", imem_rvalid, imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (EN_PC_O !== 1'b0 || imem_addr !== rpc || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstall_after got=en%b/%h/req%b exp=en0/%h/req1", EN_PC_O, imem_addr, imem_req, rpc);
    end
    next_cycle();
    stall = 1'b0;
    wait_first_head("rstall", rpc);
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    next_cycle();
    redirect = 1'b0;
    got_pc.delete(); got_in.delete();
    @(negedge CLK);
    n_tests++;
    if (imem_addr !== 32'hFFFF_FFFF || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_top got=%h/%b exp=ffffffff/1", imem_addr, imem_req);
    end
    next_cycle();
    @(negedge CLK);
    n_tests++;
    if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=00000000", imem_addr); end
    repeat (8) next_cycle();
    n_tests++;
    if (got_pc.size() < 3) begin
      n_fail++; $display("FAIL wrap_count got=%0d exp=>=3", got_pc.size());
    end else if (got_pc[0] !== 32'hFFFF_FFFF || got_pc[1] !== 32'h0 || got_pc[2] !== 32'h1 ||
                 got_in[1] !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL wrap_seq got=%h,%h,%h exp=ffffffff,00000000,00000001", got_pc[0], got_pc[1], got_pc[2]);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (EN_PC_O !== 1'b0 || PC_O !== 32'h0 || instr_O !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async got=en%b/%h/%h/req%b exp=en0/0/0/req0", EN_PC_O, PC_O, instr_O, imem_req);
    end
    repeat (2) next_cycle();
    rst_n = 1'b1;
    got_pc.delete(); got_in.delete();
    @(negedge CLK);
    n_tests++;
    if (imem_addr !== RESET_PC || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL midrst_restart got=%h/%b exp=%h/1", imem_addr, imem_req, RESET_PC);
    end
    next_cycle();
    wait_first_head("midrst", RESET_PC);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, pend_pc;
    bit pend;
    int consumed;
    rand_lat = 1'b1;
    do_reset();
    exp_pc = RESET_PC; pend = 1'b0; pend_pc = '0; consumed = 0;
    for (int c = 0; c < 600; c++) begin
      while (got_pc.size() > 0) begin
        n_tests++;
        if (got_pc[0] !== exp_pc || got_in[0] !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rand_seq cyc=%0d got=%h/%h exp=%h/%h", c, got_pc[0], got_in[0], exp_pc, mem_word(exp_pc));
        end
        void'(got_pc.pop_front()); void'(got_in.pop_front());
        exp_pc = exp_pc + 32'd1;
        consumed++;
      end
      if (pend) exp_pc = pend_pc;
      stall       = ($urandom_range(3, 0) == 0);
      imem_gnt    = ($urandom_range(3, 0) != 0);
      redirect    = ($urandom_range(15, 0) == 0);
      redirect_pc = $urandom;
      pend = redirect; pend_pc = redirect_pc;
      next_cycle();
    end
    redirect = 1'b0; stall = 1'b0; imem_gnt = 1'b1; rand_lat = 1'b0;
    n_tests++;
    if (consumed < 100) begin n_fail++; $display("FAIL rand_progress got=%0d exp=>=100", consumed); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gnt_wait();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
